// File: rtl/mm_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mm_job_sequencer
// Purpose  : Runs one matrix-multiply job on the shared serial MM engine.
//            Reads two row-major 8-bit matrices from source memory, streams
//            them into the engine with col_end/row_end framing, then collects
//            the engine's result stream into destination memory and reports
//            done / err / err_code / ovf_cnt to the host.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            start, m*_rows/cols,   - job request and configuration
//            src_base, dst_base
//            rd_en/rd_addr/rd_data  - source memory (data one cycle later)
//            mm_in_data, mm_col_end,
//            mm_row_end             - operand stream to the engine
//            mm_busy, mm_valid, mm_is_legal, mm_overflow, mm_out_data,
//            mm_ep                  - engine status and results
//            wr_en/wr_addr/wr_data  - destination memory
//            busy, done, err, err_code, ovf_cnt - host status
// Options  : CTRL_WDOG_EN - 8-bit watchdog on GAP / WAIT_RES; timeout ends
//            the job with err=1, err_code=2'b11.
// Revision : 1.0 - initial release
// ============================================================================
module mm_job_sequencer #(
    parameter int AW    = 8,
    parameter int DIM_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] m1_rows,
    input  logic [DIM_W-1:0] m1_cols,
    input  logic [DIM_W-1:0] m2_rows,
    input  logic [DIM_W-1:0] m2_cols,
    input  logic [AW-1:0]    src_base,
    input  logic [AW-1:0]    dst_base,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [7:0]       rd_data,
    output logic [7:0]       mm_in_data,
    output logic             mm_col_end,
    output logic             mm_row_end,
    input  logic             mm_busy,
    input  logic             mm_valid,
    input  logic             mm_is_legal,
    input  logic             mm_overflow,
    input  logic [11:0]      mm_out_data,
    input  logic [1:0]       mm_ep,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [12:0]      wr_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [4:0]       ovf_cnt
);

    // Element counts are products of two dimension fields.
    localparam int               CW        = 2 * DIM_W;
    localparam logic [DIM_W-1:0] c_MAX_DIM = DIM_W'(4);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FEED1    = 3'd1,
        S_GAP      = 3'd2,
        S_FEED2    = 3'd3,
        S_WAIT_RES = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [DIM_W-1:0] r_m1_cols;
    logic [DIM_W-1:0] r_m2_cols;
    logic [AW-1:0]    r_src;
    logic [AW-1:0]    r_dst;
    logic [CW-1:0]    r_n1;
    logic [CW-1:0]    r_n2;
    logic [CW-1:0]    r_nres;
    logic [CW-1:0]    r_idx;
    logic [DIM_W-1:0] r_col;
    logic [CW-1:0]    r_k;
    logic             r_gap_idle;
    logic             r_feed_vld;
    logic             r_col_end_q;
    logic             r_row_end_q;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [4:0]       r_ovf_cnt;

    logic             w_cfg_bad;
    logic             w_feed;
    logic [DIM_W-1:0] w_cols;
    logic [CW-1:0]    w_n;
    logic             w_last_col;
    logic             w_last_elem;
    logic             w_res_ok;
    logic             w_res_bad;
    logic             w_res_last;
    logic             w_wait_state;
    logic             w_wdog_fire;

    assign w_cfg_bad = (m1_rows == '0) || (m1_rows > c_MAX_DIM) ||
                       (m1_cols == '0) || (m1_cols > c_MAX_DIM) ||
                       (m2_rows == '0) || (m2_rows > c_MAX_DIM) ||
                       (m2_cols == '0) || (m2_cols > c_MAX_DIM);

    assign w_feed       = (r_state == S_FEED1) || (r_state == S_FEED2);
    assign w_cols       = (r_state == S_FEED2) ? r_m2_cols : r_m1_cols;
    assign w_n          = (r_state == S_FEED2) ? r_n2 : r_n1;
    assign w_last_col   = (r_col == w_cols - DIM_W'(1));
    assign w_last_elem  = (r_idx == w_n - CW'(1));
    assign w_res_ok     = (r_state == S_WAIT_RES) && mm_valid && mm_is_legal;
    assign w_res_bad    = (r_state == S_WAIT_RES) && mm_valid && !mm_is_legal;
    assign w_res_last   = w_res_ok && ((r_k + CW'(1)) == r_nres);
    assign w_wait_state = (r_state == S_GAP) || (r_state == S_WAIT_RES);

`ifdef CTRL_WDOG_EN
    // Counts idle cycles while waiting on the engine; any result or state
    // change restarts the count. A result arriving on the timeout cycle wins.
    logic [7:0] r_wdog;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= 8'd0;
        end else if (w_wait_state && (w_next == r_state) && !mm_valid) begin
            r_wdog <= r_wdog + 8'd1;
        end else begin
            r_wdog <= 8'd0;
        end
    end

    assign w_wdog_fire = w_wait_state && (r_wdog == 8'hFF) && !mm_valid;
`else
    assign w_wdog_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        mm_in_data = r_feed_vld ? rd_data : 8'd0;
        mm_col_end = r_col_end_q;
        mm_row_end = r_row_end_q;
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        err        = r_err;
        err_code   = r_err_code;
        ovf_cnt    = r_ovf_cnt;

        if (w_feed) begin
            rd_en   = 1'b1;
            // Matrix 2 sits directly after matrix 1; sum wraps modulo 2^AW.
            rd_addr = r_src + AW'(r_idx) +
                      ((r_state == S_FEED2) ? AW'(r_n1) : AW'(0));
        end

        if (w_res_ok) begin
            wr_en   = 1'b1;
            wr_addr = r_dst + AW'(r_k);
            wr_data = {mm_overflow, mm_out_data};
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_cfg_bad ? S_DONE : S_FEED1;
                end
            end
            S_FEED1: begin
                if (w_last_elem) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                // First GAP cycle carries matrix-1 row_end on the stream;
                // the second is the mandatory idle cycle.
                if (w_wdog_fire) begin
                    w_next = S_DONE;
                end else if (r_gap_idle && !mm_busy) begin
                    w_next = S_FEED2;
                end
            end
            S_FEED2: begin
                if (w_last_elem) begin
                    w_next = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (w_res_bad || w_res_last || w_wdog_fire) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, counters and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m1_cols   <= '0;
            r_m2_cols   <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_n1        <= '0;
            r_n2        <= '0;
            r_nres      <= '0;
            r_idx       <= '0;
            r_col       <= '0;
            r_k         <= '0;
            r_gap_idle  <= 1'b0;
            r_feed_vld  <= 1'b0;
            r_col_end_q <= 1'b0;
            r_row_end_q <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
            r_ovf_cnt   <= 5'd0;
        end else begin
            // Framing travels one cycle behind rd_en, alongside rd_data.
            r_feed_vld  <= w_feed;
            r_col_end_q <= w_feed && w_last_col;
            r_row_end_q <= w_feed && w_last_elem;
            r_gap_idle  <= (r_state == S_GAP);

            if (w_next != r_state) begin
                r_idx <= '0;
                r_col <= '0;
            end else if (w_feed) begin
                r_idx <= r_idx + CW'(1);
                r_col <= w_last_col ? '0 : r_col + DIM_W'(1);
            end

            if ((r_state == S_IDLE) && start) begin
                r_m1_cols  <= m1_cols;
                r_m2_cols  <= m2_cols;
                r_src      <= src_base;
                r_dst      <= dst_base;
                r_n1       <= CW'(m1_rows) * CW'(m1_cols);
                r_n2       <= CW'(m2_rows) * CW'(m2_cols);
                r_nres     <= CW'(m1_rows) * CW'(m2_cols);
                r_k        <= '0;
                r_err      <= w_cfg_bad;
                r_err_code <= 2'b00;
                r_ovf_cnt  <= 5'd0;
            end

            if (w_res_ok) begin
                r_k <= r_k + CW'(1);
                if (mm_overflow && (r_ovf_cnt != 5'd31)) begin
                    r_ovf_cnt <= r_ovf_cnt + 5'd1;
                end
            end

            if (w_res_bad) begin
                r_err      <= 1'b1;
                r_err_code <= mm_ep;
            end else if (w_wdog_fire) begin
                r_err      <= 1'b1;
                r_err_code <= 2'b11;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mm_job_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mm_job_sequencer
// Purpose  : Directed self-checking bench for mm_job_sequencer with a source
//            memory model, a stream/write logger and a hand-driven engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_job_sequencer;

    localparam int AW    = 8;
    localparam int DIM_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DIM_W-1:0] m1_rows, m1_cols, m2_rows, m2_cols;
    logic [AW-1:0]    src_base, dst_base;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd_data = 8'd0;
    logic [7:0]       mm_in_data;
    logic             mm_col_end, mm_row_end;
    logic             mm_busy, mm_valid, mm_is_legal, mm_overflow;
    logic [11:0]      mm_out_data;
    logic [1:0]       mm_ep;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [12:0]      wr_data;
    logic             busy, done, err;
    logic [1:0]       err_code;
    logic [4:0]       ovf_cnt;

    mm_job_sequencer #(.AW(AW), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .m1_rows(m1_rows), .m1_cols(m1_cols), .m2_rows(m2_rows), .m2_cols(m2_cols),
        .src_base(src_base), .dst_base(dst_base),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .mm_in_data(mm_in_data), .mm_col_end(mm_col_end), .mm_row_end(mm_row_end),
        .mm_busy(mm_busy), .mm_valid(mm_valid), .mm_is_legal(mm_is_legal),
        .mm_overflow(mm_overflow), .mm_out_data(mm_out_data), .mm_ep(mm_ep),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    // Source memory: data returned the cycle after rd_en.
    logic [7:0] mem [0:255];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Logger: sampled on the falling edge.
    logic [AW-1:0] rd_log [$];
    logic [7:0]    st_data[$];
    logic          st_ce  [$];
    logic          st_re  [$];
    logic [AW-1:0] wa_log [$];
    logic [12:0]   wd_log [$];
    int            done_cnt = 0;
    int            stray    = 0;
    logic          prev_rd  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_rd = 1'b0;
        end else begin
            if (prev_rd) begin
                st_data.push_back(mm_in_data);
                st_ce.push_back(mm_col_end);
                st_re.push_back(mm_row_end);
            end else if (mm_col_end || mm_row_end || (mm_in_data != 8'd0)) begin
                stray++;
            end
            if (rd_en) rd_log.push_back(rd_addr);
            if (wr_en) begin
                wa_log.push_back(wr_addr);
                wd_log.push_back(wr_data);
            end
            if (done) done_cnt++;
            prev_rd = rd_en;
        end
    end

    task automatic clear_log();
        rd_log.delete(); st_data.delete(); st_ce.delete(); st_re.delete();
        wa_log.delete(); wd_log.delete();
        done_cnt = 0;
        stray    = 0;
    endtask

    task automatic start_job(input int r1, input int c1, input int r2, input int c2,
                             input int src, input int dst);
        @(posedge clk); #1;
        m1_rows  = DIM_W'(r1); m1_cols = DIM_W'(c1);
        m2_rows  = DIM_W'(r2); m2_cols = DIM_W'(c2);
        src_base = AW'(src);   dst_base = AW'(dst);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_stream(input int n);
        for (int i = 0; i < 300 && st_data.size() < n; i++) @(negedge clk);
        check("stream_count", st_data.size(), n);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [11:0] d, input logic ovf, input logic legal,
                        input logic [1:0] ep);
        mm_valid = 1'b1; mm_out_data = d; mm_overflow = ovf;
        mm_is_legal = legal; mm_ep = ep;
        @(posedge clk); #1;
        mm_valid = 1'b0; mm_out_data = 12'd0; mm_overflow = 1'b0;
        mm_is_legal = 1'b0; mm_ep = 2'b00;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < bound && done_cnt == c0; i++) @(negedge clk);
        check(tag, done_cnt - c0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        m1_rows = '0; m1_cols = '0; m2_rows = '0; m2_cols = '0;
        src_base = '0; dst_base = '0;
        mm_busy = 1'b0; mm_valid = 1'b0; mm_is_legal = 1'b0; mm_overflow = 1'b0;
        mm_out_data = 12'd0; mm_ep = 2'b00;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;

        // ---- Reset state ----
        repeat (3) @(negedge clk);
        check("rst_out_a", {rd_en, rd_addr, mm_in_data, mm_col_end, mm_row_end, wr_en, wr_addr}, 32'd0);
        check("rst_out_b", {wr_data, busy, done, err, err_code, ovf_cnt}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // ---- Test 1: 2x2 x 2x2 ----
        for (int i = 0; i < 8; i++) mem[8'h10 + i] = 8'(i + 1);
        clear_log();
        start_job(2, 2, 2, 2, 8'h10, 8'h40);
        wait_stream(8);
        send(12'd19, 1'b0, 1'b1, 2'b00);
        send(12'd22, 1'b0, 1'b1, 2'b00);
        send(12'd43, 1'b0, 1'b1, 2'b00);
        send(12'd50, 1'b0, 1'b1, 2'b00);
        wait_done(10, "t1_done");
        check("t1_rd_count", rd_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_rd_addr%0d", i), rd_log[i], 8'h10 + i);
            check($sformatf("t1_data%0d", i), st_data[i], i + 1);
            check($sformatf("t1_ce%0d", i), st_ce[i], (i % 2) == 1);
            check($sformatf("t1_re%0d", i), st_re[i], (i == 3) || (i == 7));
        end
        check("t1_wr_count", wa_log.size(), 4);
        check("t1_wr0", {wa_log[0], wd_log[0]}, {8'h40, 13'd19});
        check("t1_wr1", {wa_log[1], wd_log[1]}, {8'h41, 13'd22});
        check("t1_wr2", {wa_log[2], wd_log[2]}, {8'h42, 13'd43});
        check("t1_wr3", {wa_log[3], wd_log[3]}, {8'h43, 13'd50});
        check("t1_status", {busy, err, err_code, ovf_cnt}, 9'd0);
        check("t1_stray", stray, 0);

        // ---- Test 2: 2x3 x 2x2, engine reports illegal ----
        clear_log();
        start_job(2, 3, 2, 2, 8'h10, 8'h40);
        wait_stream(10);
        check("t2_ce_pos", {st_ce[2], st_ce[5], st_ce[7], st_ce[9], st_ce[1]}, 5'b11110);
        check("t2_re_pos", {st_re[5], st_re[9], st_re[2]}, 3'b110);
        send(12'd0, 1'b0, 1'b0, 2'b00);
        wait_done(10, "t2_done");
        repeat (3) @(negedge clk);
        check("t2_done_once", done_cnt, 1);
        check("t2_no_write", wa_log.size(), 0);
        check("t2_err", {err, err_code}, 3'b100);

        // Same job, engine error code 2'b10 must be latched.
        clear_log();
        start_job(2, 3, 2, 2, 8'h10, 8'h40);
        wait_stream(10);
        send(12'd0, 1'b0, 1'b0, 2'b10);
        wait_done(10, "t2b_done");
        check("t2b_err", {err, err_code}, 3'b110);

        // ---- Test 3: m2_cols = 0 rejected locally ----
        clear_log();
        start_job(2, 2, 2, 0, 8'h10, 8'h40);
        wait_done(2, "t3_done_fast");
        repeat (3) @(negedge clk);
        check("t3_no_read", rd_log.size(), 0);
        check("t3_err", {busy, err, err_code}, 4'b0100);

        // ---- Test 4: 1x4 x 4x1 of 127, overflowed result ----
        for (int i = 0; i < 8; i++) mem[8'h20 + i] = 8'd127;
        clear_log();
        start_job(1, 4, 4, 1, 8'h20, 8'h50);
        check("t4_err_cleared", {err, err_code}, 3'b000);
        wait_stream(8);
        send(12'h7FF, 1'b1, 1'b1, 2'b00);
        wait_done(10, "t4_done");
        check("t4_wr_count", wa_log.size(), 1);
        check("t4_wr0", {wa_log[0], wd_log[0]}, {8'h50, 13'h17FF});
        check("t4_ovf", {err, ovf_cnt}, {1'b0, 5'd1});
        check("t4_ce_count", st_ce.sum() with (int'(item)), 5);
        check("t4_re_count", st_re.sum() with (int'(item)), 2);

        // ---- Test 5: wrap at 0xFE and start ignored during FEED2 ----
        mem[8'hFE] = 8'd1; mem[8'hFF] = 8'd2;
        for (int i = 0; i < 6; i++) mem[i] = 8'(i + 3);
        clear_log();
        start_job(2, 2, 2, 2, 8'hFE, 8'h60);
        for (int i = 0; i < 50 && rd_log.size() < 5; i++) @(negedge clk);
        start_job(1, 1, 1, 1, 8'h80, 8'h90);
        wait_stream(8);
        send(12'd19, 1'b0, 1'b1, 2'b00);
        send(12'd22, 1'b0, 1'b1, 2'b00);
        send(12'd43, 1'b0, 1'b1, 2'b00);
        send(12'd50, 1'b0, 1'b1, 2'b00);
        wait_done(10, "t5_done");
        repeat (20) @(negedge clk);
        check("t5_done_once", done_cnt, 1);
        check("t5_rd_count", rd_log.size(), 8);
        check("t5_rd_wrap", {rd_log[0], rd_log[1], rd_log[2], rd_log[7]}, 32'hFEFF0005);
        check("t5_data", {st_data[1], st_data[2], st_data[7]}, {8'd2, 8'd3, 8'd8});
        check("t5_wr_count", wa_log.size(), 4);
        check("t5_wr3", {wa_log[3], wd_log[3]}, {8'h63, 13'd50});
        check("t5_idle", busy, 1'b0);

        // ---- Test 6: reset in the middle of FEED1 ----
        clear_log();
        start_job(2, 2, 2, 2, 8'h10, 8'h40);
        for (int i = 0; i < 20 && rd_log.size() < 2; i++) @(negedge clk);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        check("t6_out_a", {rd_en, rd_addr, mm_in_data, mm_col_end, mm_row_end, wr_en, wr_addr}, 32'd0);
        check("t6_out_b", {wr_data, busy, done, err, err_code, ovf_cnt}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_no_done", {busy, 31'(done_cnt)}, 32'd0);

`ifdef CTRL_WDOG_EN
        // ---- Watchdog: engine never returns a result ----
        clear_log();
        start_job(2, 2, 2, 2, 8'h10, 8'h40);
        wait_stream(8);
        wait_done(400, "wd_done");
        check("wd_err", {err, err_code}, 3'b111);
        check("wd_no_write", wa_log.size(), 0);
`else
        // ---- No watchdog: controller keeps waiting ----
        clear_log();
        start_job(2, 2, 2, 2, 8'h10, 8'h40);
        wait_stream(8);
        repeat (300) @(negedge clk);
        check("nowd_waiting", {busy, 31'(done_cnt)}, 32'h80000000);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("nowd_reset_idle", busy, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
